// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame transmitter and its receive-side checker.
package frame_pkg;

  localparam int WORD_W   = 32;
  localparam int PRE_W    = 8;
  localparam int GAP_BITS = 2;
  localparam int CNT_W    = 6;

  localparam logic [PRE_W-1:0] PREAMBLE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

endpackage

// File: rtl/frame_tx.sv
// Serial frame transmitter: preamble 8'hA5, 32-bit payload MSB first, optional parity, 2 gap bits.
// Parity bit is included when FRAME_PARITY_EN is defined.
module frame_tx
  import frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] data_in,
  output logic              in_ready,
  output logic              data_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int SH_W = PRE_W + WORD_W - 1;
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  // Holds the bits still to be sent after the one on data_out; next bit is always the MSB.
  logic [SH_W-1:0]   shreg;
`ifdef FRAME_PARITY_EN
  logic              par_bit;
`endif

  // Handshake: a word is taken on a rising edge with in_valid=1 and in_ready=1 (IDLE only).
  assign in_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data_out   <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= {PREAMBLE[PRE_W-2:0], data_in};
            data_out <= PREAMBLE[PRE_W-1];
            cnt      <= '0;
            state    <= PRE;
`ifdef FRAME_PARITY_EN
            par_bit  <= ^data_in;
`endif
          end
        end
        PRE: begin
          if (bit_en) begin
            data_out <= shreg[SH_W-1];
            shreg    <= shreg << 1;
            if (cnt == PRE_LAST) begin
              cnt   <= '0;
              state <= DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (bit_en) begin
            if (cnt == DATA_LAST) begin
              cnt <= '0;
`ifdef FRAME_PARITY_EN
              data_out <= par_bit;
              state    <= PAR;
`else
              data_out <= 1'b0;
              state    <= GAP;
`endif
            end else begin
              data_out <= shreg[SH_W-1];
              shreg    <= shreg << 1;
              cnt      <= cnt + 1'b1;
            end
          end
        end
`ifdef FRAME_PARITY_EN
        PAR: begin
          if (bit_en) begin
            data_out <= 1'b0;
            state    <= GAP;
          end
        end
`endif
        GAP: begin
          if (bit_en) begin
            if (cnt == GAP_LAST) begin
              cnt        <= '0;
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          data_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: hand-computed line images, back-to-back, bit_en stalls, reset cases.
// Parity scenarios are compiled in when FRAME_PARITY_EN is defined.
module tb_frame_tx;

`ifdef FRAME_PARITY_EN
  localparam int FB = 43;
  localparam logic [FB-1:0] L_DEADBEEF = 43'h52EF56DF778;
  localparam logic [FB-1:0] L_W1       = 43'h5280000000C;
  localparam logic [FB-1:0] L_W2       = 43'h52800000014;
  localparam logic [FB-1:0] L_12345678 = 43'h52891A2B3C4;
  localparam logic [FB-1:0] L_W7       = 43'h5280000003C;
  localparam logic [FB-1:0] L_W3       = 43'h52800000018;
`else
  localparam int FB = 42;
  localparam logic [FB-1:0] L_DEADBEEF = 42'h2977AB6FBBC;
  localparam logic [FB-1:0] L_W1       = 42'h29400000004;
  localparam logic [FB-1:0] L_W2       = 42'h29400000008;
  localparam logic [FB-1:0] L_12345678 = 42'h29448D159E0;
`endif

  logic        clk;
  logic        rst_n;
  logic        bit_en;
  logic        in_valid;
  logic [31:0] data_in;
  logic        in_ready;
  logic        data_out;
  logic        tx_busy;
  logic        frame_done;

  int n_vec;
  int n_err;

  frame_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame and checks the line every cycle. bit_en strobes on every period-th
  // cycle after the handshake, so each bit should be held exactly period cycles.
  task automatic send_frame(input string tag, input logic [31:0] word,
                            input logic [FB-1:0] exp_line, input int period,
                            input bit hold_valid, input bit corrupt, input int abort_bit,
                            output logic [FB-1:0] line);
    int bits;
    int line_err;
    int early_done;
    int idx;
    bits       = 0;
    line_err   = 0;
    early_done = 0;
    line       = '0;
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    data_in  = word;
    bit_en   = 1'b0;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    if (corrupt) data_in = 32'hFFFF_FFFF;
    for (int k = 1; k <= FB * period + 2 && bits < FB; k++) begin
      idx = FB - 1 - ((k - 1) / period);
      if (data_out !== exp_line[idx]) line_err++;
      if (!tx_busy) line_err++;
      if (frame_done) early_done++;
      if (abort_bit >= 0 && k == (8 + abort_bit) * period + 1) begin
        check({tag, "_pre_abort"}, 64'(line_err), 64'd0);
        rst_n  = 1'b0;
        bit_en = 1'b0;
        @(negedge clk);
        check({tag, "_abort_line"}, 64'(data_out), 64'd0);
        check({tag, "_abort_busy"}, 64'(tx_busy), 64'd0);
        check({tag, "_abort_done"}, 64'(frame_done), 64'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_abort_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_abort_nodone"}, 64'(frame_done), 64'd0);
        return;
      end
      bit_en = ((k % period) == 0);
      if (bit_en) begin
        line[FB-1-bits] = data_out;
        bits++;
      end
      @(negedge clk);
    end
    bit_en = 1'b0;
    check({tag, "_line"}, 64'(line), 64'(exp_line));
    check({tag, "_percycle"}, 64'(line_err), 64'd0);
    check({tag, "_no_early_done"}, 64'(early_done), 64'd0);
    check({tag, "_done"}, 64'(frame_done), 64'd1);
    check({tag, "_busy_end"}, 64'(tx_busy), 64'd0);
  endtask

  initial begin
    logic [FB-1:0] line;
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bit_en   = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_busy", 64'(tx_busy), 64'd0);

    // Scenario 1: continuous bit_en
    send_frame("s1", 32'hDEAD_BEEF, L_DEADBEEF, 1, 1'b0, 1'b0, -1, line);
    @(negedge clk);
    check("s1_done_one_cycle", 64'(frame_done), 64'd0);

    // Scenario 2: bit_en every 8th cycle
    send_frame("s2", 32'h0000_0001, L_W1, 8, 1'b0, 1'b0, -1, line);

    // Scenario 3: in_valid held high across two frames, no idle cycle between them
    send_frame("s3a", 32'h0000_0001, L_W1, 1, 1'b1, 1'b0, -1, line);
    send_frame("s3b", 32'h0000_0002, L_W2, 1, 1'b0, 1'b0, -1, line);

    // Scenario 4: data_in changed right after the handshake
    send_frame("s4", 32'h1234_5678, L_12345678, 1, 1'b0, 1'b1, -1, line);

    // Scenario 5: reset at payload bit 10, then a clean frame
    send_frame("s5_abort", 32'hDEAD_BEEF, L_DEADBEEF, 1, 1'b0, 1'b0, 10, line);
    send_frame("s5_after", 32'h1234_5678, L_12345678, 3, 1'b0, 1'b0, -1, line);

    // Reset coinciding with a handshake drops the word
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 32'hAAAA_5555;
    @(negedge clk);
    check("rst_hs_busy", 64'(tx_busy), 64'd0);
    check("rst_hs_line", 64'(data_out), 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_hs_dropped", 64'(tx_busy), 64'd0);

`ifdef FRAME_PARITY_EN
    // Scenario 6: parity bit sits right before the two gap bits
    send_frame("s6a", 32'h0000_0007, L_W7, 1, 1'b0, 1'b0, -1, line);
    check("s6a_parity", 64'(line[2]), 64'd1);
    send_frame("s6b", 32'h0000_0003, L_W3, 2, 1'b0, 1'b0, -1, line);
    check("s6b_parity", 64'(line[2]), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
